// File: rtl/ex_muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer beside the EX-stage ALU.
// One shared radix-2 datapath: shift-add multiply, restoring divide.
module ex_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [4:0]      i_rd_in,
    output logic            o_stall_req,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_out
);

    localparam int W2 = 2 * XLEN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W2:0]     r_acc;
    logic [XLEN-1:0] r_b;
    logic            r_neg;
    logic [2:0]      r_f3;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_out;

    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_neg_flag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;

    logic [XLEN:0]   w_hi;
    logic [XLEN:0]   w_sum;
    logic [W2:0]     w_mul_next;
    logic [W2:0]     w_shl;
    logic [XLEN+1:0] w_trial;
    logic [W2:0]     w_div_next;

    logic [W2-1:0]   w_prod;
    logic [W2-1:0]   w_prod_f;
    logic [XLEN-1:0] w_quo_f;
    logic [XLEN-1:0] w_rem_f;
    logic [XLEN-1:0] w_fix;

    assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;

    // MUL, MULH, MULHSU, DIV, REM treat op_a as signed; MULHSU leaves op_b unsigned
    assign w_a_signed = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                        (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign w_b_signed = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                        (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign w_a_neg    = w_a_signed && i_op_a[XLEN-1];
    assign w_b_neg    = w_b_signed && i_op_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? (~i_op_a + 1'b1) : i_op_a;
    assign w_abs_b    = w_b_neg ? (~i_op_b + 1'b1) : i_op_b;
    assign w_neg_flag = (i_funct3 == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div0 = i_funct3[2] && (i_op_b == '0);
    assign w_ovf  = i_funct3[2] && !i_funct3[0] && (i_op_a == MIN_NEG) && (i_op_b == ALL_ONES);

    always_comb begin
        w_special = '0;
        if (w_div0)
            w_special = i_funct3[1] ? i_op_a : ALL_ONES;
        else if (w_ovf)
            w_special = i_funct3[1] ? '0 : MIN_NEG;
    end

    // Multiply step: conditional add into the high half, then shift right
    assign w_hi       = r_acc[W2:XLEN];
    assign w_sum      = w_hi + {1'b0, r_b};
    assign w_mul_next = {1'b0, (r_acc[0] ? w_sum : w_hi), r_acc[XLEN-1:1]};

    // Divide step: shift remainder:dividend left, keep trial difference if no borrow
    assign w_shl      = {r_acc[W2-1:0], 1'b0};
    assign w_trial    = {1'b0, w_shl[W2:XLEN]} - {2'b00, r_b};
    assign w_div_next = w_trial[XLEN+1] ? w_shl : {w_trial[XLEN:0], w_shl[XLEN-1:1], 1'b1};

    assign w_prod   = r_acc[W2-1:0];
    assign w_prod_f = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_f  = r_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem_f  = r_neg ? (~r_acc[W2-1:XLEN] + 1'b1) : r_acc[W2-1:XLEN];

    always_comb begin
        w_fix = '0;
        case (r_f3)
            3'b000:                 w_fix = w_prod_f[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod_f[W2-1:XLEN];
            3'b100, 3'b101:         w_fix = w_quo_f;
            default:                w_fix = w_rem_f;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_f3     <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_f3  <= i_funct3;
                        r_rd  <= i_rd_in;
                        r_neg <= w_neg_flag;
                        r_acc <= {{(XLEN+1){1'b0}}, w_abs_a};
                        r_b   <= w_abs_b;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special;
                            r_rd_out <= i_rd_in;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(XLEN);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_f3[2] ? w_div_next : w_mul_next;
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= CNT_W'(1))
                        r_state <= S_FIXUP;
                end
                S_FIXUP: begin
                    r_result <= w_fix;
                    r_rd_out <= r_rd;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall_req = !i_rst && (w_accept || (r_state == S_CALC) || (r_state == S_FIXUP));
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_rd_out    = r_rd_out;

endmodule
